// File: rtl/spi_block_sender_pkg.sv
// Shared SPI definitions for the voter-side sender and the tally-side
// receiver (spi_pe).
//   spi_sender_state_t  : sender control states
//   SPI_DATA_WIDTH      : default bits per SPI word
//   SPI_DATA_CLK_PERIOD : default system clocks per DCLK period
//   cnt_width()         : counter width for a 0..n-1 range, never below 1
package spi_pkg;

  localparam int unsigned SPI_DATA_WIDTH      = 32;
  localparam int unsigned SPI_DATA_CLK_PERIOD = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    GAP
  } spi_sender_state_t;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_block_sender_evt_counter.sv
// Event counter that wraps at MAX_COUNT.
//   clk_in    : system clock
//   rst_in    : asynchronous active-low reset
//   evt_in    : one-cycle increment strobe
//   count_out : events seen since the last wrap (0..MAX_COUNT-1)
//   wrap_out  : one-cycle pulse in the cycle the count wraps to 0
module evt_counter #(
  parameter int unsigned MAX_COUNT = 128
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         evt_in,
  output logic [$clog2(MAX_COUNT)-1:0] count_out,
  output logic                         wrap_out
);

  localparam int unsigned CW = $clog2(MAX_COUNT);
  localparam logic [CW-1:0] LAST = CW'(MAX_COUNT - 1);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      count_out <= '0;
      wrap_out  <= 1'b0;
    end else begin
      wrap_out <= 1'b0;
      if (evt_in) begin
        if (count_out == LAST) begin
          count_out <= '0;
          wrap_out  <= 1'b1;
        end else begin
          count_out <= count_out + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/spi_block_sender.sv
// SPI mode-0 block sender: streams DATA_WIDTH-bit words MSB-first, one word
// per chip-select window, and counts words into frames of NUM_BLOCKS.
//   clk_in          : system clock
//   rst_in          : asynchronous active-low reset
//   data_in         : word to send, latched on accept
//   valid_in        : data_in is valid
//   ready_out       : a word can be accepted this cycle
//   block_count_out : words completed in the current frame
//   frame_done_out  : one-cycle pulse when the last word of a frame completes
//   chip_data_out   : COPI
//   chip_clk_out    : DCLK (idles low)
//   chip_sel_out    : CS, active-low
module spi_block_sender
  import spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = SPI_DATA_WIDTH,
  parameter int unsigned DATA_CLK_PERIOD = SPI_DATA_CLK_PERIOD,
  parameter int unsigned NUM_BLOCKS      = 128,
  parameter int unsigned CS_IDLE_CYCLES  = 4
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [DATA_WIDTH-1:0]         data_in,
  input  logic                          valid_in,
  output logic                          ready_out,
  output logic [$clog2(NUM_BLOCKS)-1:0] block_count_out,
  output logic                          frame_done_out,
  output logic                          chip_data_out,
  output logic                          chip_clk_out,
  output logic                          chip_sel_out
);

  if ((DATA_CLK_PERIOD < 2) || (DATA_CLK_PERIOD % 2 != 0)) begin : g_bad_period
    $error("spi_block_sender: DATA_CLK_PERIOD must be even and >= 2");
  end
  if (CS_IDLE_CYCLES == 0) begin : g_bad_idle
    $error("spi_block_sender: CS_IDLE_CYCLES must be >= 1");
  end

  localparam int unsigned H     = DATA_CLK_PERIOD / 2;
  localparam int unsigned DIV_W = cnt_width(H);
  localparam int unsigned BIT_W = cnt_width(DATA_WIDTH);
  localparam int unsigned GAP_W = cnt_width(CS_IDLE_CYCLES);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(H - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(CS_IDLE_CYCLES - 1);

  spi_sender_state_t state, next_state;

  logic [DIV_W-1:0]      div_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [GAP_W-1:0]      gap_cnt;
  logic [DATA_WIDTH-1:0] shreg;

  logic accept;
  logic half_tick;
  logic last_fall;
  logic gap_done;

  // ready_out is high exactly while in IDLE, so it doubles as the accept gate.
  assign accept    = ready_out && valid_in;
  // The divider runs through LOAD as well: LOAD is the first clock of the
  // first DCLK low half, which puts the first rising edge H clocks after CS falls.
  assign half_tick = ((state == LOAD) || (state == SHIFT)) && (div_cnt == DIV_LAST);
  // Falling edge after the last rising edge: ends the word and enters GAP.
  assign last_fall = half_tick && chip_clk_out && (bit_cnt == BIT_LAST);
  assign gap_done  = (state == GAP) && (gap_cnt == '0);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (accept)    next_state = LOAD;
      LOAD:                   next_state = SHIFT;
      SHIFT:   if (last_fall) next_state = GAP;
      GAP:     if (gap_done)  next_state = IDLE;
      default:                next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      chip_sel_out  <= 1'b1;
      chip_clk_out  <= 1'b0;
      chip_data_out <= 1'b0;
      ready_out     <= 1'b1;
      div_cnt       <= '0;
      bit_cnt       <= '0;
      gap_cnt       <= '0;
      shreg         <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            shreg         <= data_in;
            chip_data_out <= data_in[DATA_WIDTH-1];
            chip_sel_out  <= 1'b0;
            chip_clk_out  <= 1'b0;
            ready_out     <= 1'b0;
            div_cnt       <= '0;
            bit_cnt       <= '0;
          end
        end
        LOAD, SHIFT: begin
          if (half_tick) begin
            div_cnt <= '0;
            if (!chip_clk_out) begin
              chip_clk_out <= 1'b1;
            end else if (bit_cnt == BIT_LAST) begin
              // Last falling edge coincides with CS rising and COPI returning low.
              chip_clk_out  <= 1'b0;
              chip_sel_out  <= 1'b1;
              chip_data_out <= 1'b0;
              gap_cnt       <= GAP_INIT;
            end else begin
              chip_clk_out  <= 1'b0;
              bit_cnt       <= bit_cnt + 1'b1;
              shreg         <= {shreg[DATA_WIDTH-2:0], 1'b0};
              chip_data_out <= shreg[DATA_WIDTH-2];
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            ready_out <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: begin
          chip_sel_out  <= 1'b1;
          chip_clk_out  <= 1'b0;
          chip_data_out <= 1'b0;
          ready_out     <= 1'b1;
        end
      endcase
    end
  end

  evt_counter #(
    .MAX_COUNT(NUM_BLOCKS)
  ) u_block_counter (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .evt_in   (last_fall),
    .count_out(block_count_out),
    .wrap_out (frame_done_out)
  );

endmodule

// File: tb/tb_spi_block_sender.sv
module tb_spi_block_sender;

  localparam int unsigned W   = 32;
  localparam int unsigned P_A = 8;
  localparam int unsigned P_B = 2;
  localparam int unsigned NB  = 4;
  localparam int unsigned CSI = 4;

  logic        clk;
  logic        rst;
  logic        sel;
  logic        valid;
  logic [31:0] data;

  logic       valid_a, ready_a, done_a, sdo_a, sclk_a, cs_a;
  logic       valid_b, ready_b, done_b, sdo_b, sclk_b, cs_b;
  logic [1:0] cnt_a, cnt_b;

  logic       ready_m, done_m, m_sdo, m_sclk, m_cs;
  logic [1:0] count_m;

  int checks = 0;
  int errors = 0;
  int done_pulses = 0;
  int unsigned blk_exp [2];

  // Receiver model: shift COPI on each DCLK rise while CS is low; a CS rise
  // after exactly W bits delivers a word, any other non-zero count is partial.
  logic [31:0]  rx_sh = '0;
  int unsigned  rx_bits = 0;
  int unsigned  rx_partial = 0;
  logic [31:0]  rx_q [$];

  assign valid_a = valid & ~sel;
  assign valid_b = valid & sel;
  assign ready_m = sel ? ready_b : ready_a;
  assign done_m  = sel ? done_b  : done_a;
  assign m_sdo   = sel ? sdo_b   : sdo_a;
  assign m_sclk  = sel ? sclk_b  : sclk_a;
  assign m_cs    = sel ? cs_b    : cs_a;
  assign count_m = sel ? cnt_b   : cnt_a;

  spi_block_sender #(
    .DATA_WIDTH(W), .DATA_CLK_PERIOD(P_A), .NUM_BLOCKS(NB), .CS_IDLE_CYCLES(CSI)
  ) dut_a (
    .clk_in(clk), .rst_in(rst), .data_in(data), .valid_in(valid_a),
    .ready_out(ready_a), .block_count_out(cnt_a), .frame_done_out(done_a),
    .chip_data_out(sdo_a), .chip_clk_out(sclk_a), .chip_sel_out(cs_a)
  );

  spi_block_sender #(
    .DATA_WIDTH(W), .DATA_CLK_PERIOD(P_B), .NUM_BLOCKS(NB), .CS_IDLE_CYCLES(CSI)
  ) dut_b (
    .clk_in(clk), .rst_in(rst), .data_in(data), .valid_in(valid_b),
    .ready_out(ready_b), .block_count_out(cnt_b), .frame_done_out(done_b),
    .chip_data_out(sdo_b), .chip_clk_out(sclk_b), .chip_sel_out(cs_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge m_sclk or posedge m_cs) begin
    if (m_cs === 1'b1) begin
      if (rx_bits == W) rx_q.push_back(rx_sh);
      else if (rx_bits != 0) rx_partial++;
      rx_bits = 0;
    end else begin
      rx_sh = {rx_sh[30:0], m_sdo};
      rx_bits++;
    end
  end

  always @(negedge clk) if (done_m === 1'b1) done_pulses++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit keep_valid, input bit disturb);
    int unsigned n;
    int unsigned m;
    int unsigned first_rise;
    int unsigned p;
    bit          exp_done;
    logic [31:0] got;
    p = sel ? P_B : P_A;
    n = 0;
    while (ready_m !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    chk("accept_ready", ready_m, 1);
    data  = w;
    valid = 1'b1;
    @(negedge clk);
    if (!keep_valid) valid = 1'b0;
    chk("load_cs", m_cs, 0);
    chk("load_msb", m_sdo, w[31]);
    chk("load_ready", ready_m, 0);
    n = 0;
    first_rise = 0;
    while (m_cs === 1'b0 && n < 4000) begin
      n++;
      if (m_sclk === 1'b1 && first_rise == 0) first_rise = n;
      if (disturb) begin
        valid = 1'($urandom_range(0, 1));
        data  = $urandom;
      end
      @(negedge clk);
    end
    if (!keep_valid) valid = 1'b0;
    chk("cs_low_cycles", n, W * p);
    chk("dclk_first_rise", first_rise, 1 + p / 2);
    chk("cs_rise_data", m_sdo, 0);
    chk("cs_rise_dclk", m_sclk, 0);
    exp_done = (blk_exp[sel] == NB - 1);
    blk_exp[sel] = (blk_exp[sel] + 1) % NB;
    chk("block_count", count_m, blk_exp[sel]);
    chk("frame_done", done_m, exp_done);
    m = 0;
    while (ready_m !== 1'b1 && m < 100) begin @(negedge clk); m++; end
    chk("gap_cycles", m, CSI);
    chk("rx_count", rx_q.size(), 1);
    if (rx_q.size() != 0) begin
      got = rx_q.pop_front();
      chk("rx_word", got, w);
    end
  endtask

  initial begin
    int unsigned n;
    logic [31:0] w;
    rst = 1'b0; sel = 1'b0; valid = 1'b0; data = '0;
    blk_exp[0] = 0; blk_exp[1] = 0;

    #12;
    chk("rst_cs", m_cs, 1);
    chk("rst_dclk", m_sclk, 0);
    chk("rst_data", m_sdo, 0);
    chk("rst_ready", ready_m, 1);
    chk("rst_count", count_m, 0);
    chk("rst_done", done_m, 0);
    @(negedge clk) rst = 1'b1;
    repeat (3) @(negedge clk);

    // single word, then three back-to-back words, then the busy-ignore word:
    // five words in a four-word frame
    send_word(32'hA5A5_0F0F, 1'b0, 1'b0);
    send_word(32'h0000_0001, 1'b1, 1'b0);
    send_word(32'h8000_0000, 1'b1, 1'b0);
    send_word(32'hFFFF_FFFF, 1'b0, 1'b0);
    send_word(32'hDEAD_BEEF, 1'b0, 1'b1);
    chk("frame_done_pulses", done_pulses, 1);
    repeat (20) @(negedge clk);
    chk("busy_no_extra_cs", m_cs, 1);
    chk("busy_no_extra_rx", rx_q.size(), 0);

    for (int i = 0; i < 2; i++) begin
      w = $urandom;
      send_word(w, 1'b0, 1'b0);
    end

    // reset in the middle of a word
    data = 32'hCAFE_F00D; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    n = 0;
    while (rx_bits < 10 && n < 1000) begin @(negedge clk); n++; end
    chk("mid_word_reached", rx_bits, 10);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_cs", m_cs, 1);
    chk("mid_rst_dclk", m_sclk, 0);
    chk("mid_rst_count", count_m, 0);
    chk("mid_rst_ready", ready_m, 1);
    chk("mid_rst_partial", rx_partial, 1);
    chk("mid_rst_no_word", rx_q.size(), 0);
    @(negedge clk) rst = 1'b1;
    blk_exp[0] = 0; blk_exp[1] = 0;
    repeat (2) @(negedge clk);
    send_word(32'h1234_5678, 1'b0, 1'b0);

    // minimum DCLK period instance
    sel = 1'b1;
    repeat (2) @(negedge clk);
    send_word(32'h0000_0000, 1'b0, 1'b0);
    send_word(32'hFFFF_FFFF, 1'b0, 1'b0);
    w = $urandom;
    send_word(w, 1'b0, 1'b0);

    chk("final_partial", rx_partial, 1);
    chk("final_frame_done_pulses", done_pulses, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
